// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-requester round-robin arbiter in front of one
// downstream AXI4-Lite master port. One transaction is outstanding at a time.
// A transaction that gets no done_i within TIMEOUT_CYCLES is closed with err_o
// set and zeroed read data.
module io_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        axi_aclk_i,
    input  logic        axi_aresetn_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        we0_i,
    input  logic        we1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic        done0_o,
    output logic        done1_o,
    output logic [31:0] rdata0_o,
    output logic [31:0] rdata1_o,
    output logic        err_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    input  logic        done_i,
    input  logic [31:0] rdata_i,
    output logic        busy_o
);

    // The counter has to be able to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               any_req;
    logic               grant_sel;
    logic               timeout_hit;
    logic               rr_ptr_q;
    logic               grant_q;
    logic               err_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic [CNT_W-1:0]   cnt_q;

    assign any_req     = req0_i | req1_i;
    // True in the last BUSY cycle allowed before giving up on done_i.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Pick a requester: a lone requester always wins, otherwise the pointer decides.
    always_comb begin
        grant_sel = rr_ptr_q;
        if (req0_i && !req1_i) begin
            grant_sel = 1'b0;
        end else if (req1_i && !req0_i) begin
            grant_sel = 1'b1;
        end
    end

    // Next-state logic; done_i is checked before the timeout so a late reply still completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done_i || timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping, command latch, timeout counter and response capture.
    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            rr_ptr_q <= 1'b0;
            grant_q  <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q  <= grant_sel;
                        rr_ptr_q <= ~grant_sel;
                        we_q     <= grant_sel ? we1_i    : we0_i;
                        addr_q   <= grant_sel ? addr1_i  : addr0_i;
                        wdata_q  <= grant_sel ? wdata1_i : wdata0_i;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                BUSY: begin
                    if (done_i) begin
                        rdata_q <= rdata_i;
                        err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (timeout_hit) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_o    = (state_q == BUSY);
    assign busy_o   = (state_q != IDLE);
    assign we_o     = we_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign done0_o  = (state_q == RESP) && !grant_q;
    assign done1_o  = (state_q == RESP) &&  grant_q;
    assign rdata0_o = done0_o ? rdata_q : 32'd0;
    assign rdata1_o = done1_o ? rdata_q : 32'd0;
    assign err_o    = (state_q == RESP) && err_q;

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
- REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255, setting the maximum cycles a downstream transaction may remain unacknowledged.
- REQ-002 axi_aclk_i  input  1  single clock; all state on rising edge.
- REQ-003 axi_aresetn_i  input  1  reset, asynchronous, active-low.
- REQ-004 req0_i / req1_i  input  1 each  requester 0/1 transaction request; level, held until the matching done.
- REQ-005 we0_i / we1_i  input  1 each  requester 0/1 write (1) or read (0).
- REQ-006 addr0_i / addr1_i  input  32 each  requester 0/1 address.
- REQ-007 wdata0_i / wdata1_i  input  32 each  requester 0/1 write data.
- REQ-008 done0_o / done1_o  output  1 each  one-cycle completion pulse to requester 0/1.
- REQ-009 rdata0_o / rdata1_o  output  32 each  read data to requester 0/1; valid only with the matching done.
- REQ-010 err_o  output  1  timeout flag; valid only with a done pulse.
- REQ-011 req_o  output  1  downstream request toward the AXI4-Lite master interface.
- REQ-012 we_o / addr_o / wdata_o  output  1/32/32  downstream command, registered.
- REQ-013 done_i  input  1  downstream completion pulse.
- REQ-014 rdata_i  input  32  downstream read data, valid with done_i.
- REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
- REQ-016 The FSM SHALL have states IDLE, BUSY and RESP.
- REQ-017 IDLE: if any req is high, grant one requester, latch its we/addr/wdata into we_o/addr_o/wdata_o, and go to BUSY; otherwise stay.
- REQ-018 Arbitration: round-robin pointer, 0 after reset.
  - Single requester: granted regardless of the pointer.
  - Both requesting: the pointer's requester wins.
  - The pointer moves to the other requester when a grant is made.
- REQ-019 BUSY: req_o SHALL be 1 and the command outputs SHALL be held constant.
  - On done_i: capture rdata_i, clear err, go to RESP.
- REQ-020 Timeout counter:
  - Clears on entry to BUSY and increments each BUSY cycle without done_i.
  - When it reaches TIMEOUT_CYCLES without done_i: drop req_o, set err, force captured rdata to 0, go to RESP.
  - done_i in the same cycle as the counter reaching TIMEOUT_CYCLES SHALL win (normal completion, err=0).
- REQ-021 RESP: exactly one cycle.
  - done_o of the granted requester = 1; its rdata_o = captured data; err_o = err.
  - Then go to IDLE.
- REQ-022 Latency: req sampled in IDLE at cycle N gives req_o=1 at N+1; done_i at cycle M gives done_o at M+1.
- REQ-023 One idle cycle SHALL separate consecutive transactions; at most one transaction is outstanding.
- REQ-024 Requesters SHALL drop req the cycle after done_o unless issuing a new request.
- REQ-025 A requester dropping req during BUSY SHALL NOT abort the transaction; done_o still pulses.
- REQ-026 done_i received outside BUSY SHALL be ignored.
- REQ-027 req_o SHALL be 0 in IDLE and RESP.
- REQ-028 The non-granted requester's done and rdata_o SHALL be 0.

Reset
- REQ-029 Asserting axi_aresetn_i low SHALL immediately, including mid-transaction:
  - force state IDLE;
  - clear req_o, we_o, addr_o, wdata_o, all done, rdata and err outputs, busy_o, the timeout counter, and the pointer (to 0).
- REQ-030 After reset is released, the first grant SHALL be evaluated on the first rising edge.

Verification
- REQ-031 Single read: req0=1, we0=0, addr0=0x2000_0004; done_i two cycles after req_o with rdata_i=0x0000_00A5 -> addr_o=0x2000_0004, done0_o one cycle later, rdata0_o=0xA5, err_o=0.
- REQ-032 Contention: req0 and req1 both high from reset, two transactions -> requester 0 served first, requester 1 second, one IDLE cycle between them.
- REQ-033 Fairness: req0 and req1 held continuously for 4 transactions -> grant order 0,1,0,1.
- REQ-034 Timeout: TIMEOUT_CYCLES=8, write from requester 1, done_i never asserted -> req_o falls after 8 BUSY cycles, done1_o=1, err_o=1, rdata1_o=0; a following done_i is ignored.
- REQ-035 Reset mid-BUSY: axi_aresetn_i low while req_o=1 -> req_o=0 and busy_o=0 immediately; next simultaneous request goes to requester 0.
- REQ-036 Boundary: done_i in the cycle the counter hits TIMEOUT_CYCLES -> err_o=0, rdata_i delivered.
